// File: rtl/fft_pkg.sv
// Shared types and default sizes for the FFT datapath blocks.
// The pairing buffer and the butterfly both import this package.
package fft_pkg;

  localparam int DEF_WIDTH = 9;   // signed <1.2.6>
  localparam int DEF_LANES = 16;
  localparam int DEF_DEPTH = 16;

  typedef logic signed [DEF_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAIR = 2'd2
  } pbuf_state_t;

endpackage

// File: rtl/pair_buf_mem.sv
// Block store for the pairing buffer: DEPTH entries of one complex block each.
// One synchronous write port and one combinational read port share a single address.
module pair_buf_mem #(
  parameter int WIDTH = 9,
  parameter int LANES = 16,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(DEPTH)-1:0]     addr,
  input  logic [2*LANES*WIDTH-1:0]     wdata,
  output logic [2*LANES*WIDTH-1:0]     rdata
);

  logic [2*LANES*WIDTH-1:0] mem_q [DEPTH];

  // Contents are never reset; the FSM guarantees every entry is written
  // before it is read within a frame.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/bfly_pair_buf.sv
// Input pairing buffer ahead of the radix-2 butterfly: stores the first DEPTH
// blocks of a frame, then pairs each of the next DEPTH blocks with its partner.
module bfly_pair_buf
  import fft_pkg::*;
#(
  parameter int WIDTH = fft_pkg::DEF_WIDTH,
  parameter int LANES = fft_pkg::DEF_LANES,
  parameter int DEPTH = fft_pkg::DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sof,
  input  logic                    din_valid,
  input  logic signed [WIDTH-1:0] din_i   [0:LANES-1],
  input  logic signed [WIDTH-1:0] din_q   [0:LANES-1],
  output logic signed [WIDTH-1:0] dout1_i [0:LANES-1],
  output logic signed [WIDTH-1:0] dout1_q [0:LANES-1],
  output logic signed [WIDTH-1:0] dout2_i [0:LANES-1],
  output logic signed [WIDTH-1:0] dout2_q [0:LANES-1],
  output logic                    bfly_en,
  output logic                    frame_done,
  output logic                    sof_err
);

  localparam int CW = $clog2(2*DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = 2*LANES*WIDTH;

  pbuf_state_t    state_q, state_d;
  logic [CW-1:0]  blk_cnt_q, blk_cnt_d;
  logic [BW-1:0]  d1_q, d1_d, d2_q, d2_d;
  logic           bfly_en_q, bfly_en_d;
  logic           frame_done_q, frame_done_d;
  logic           sof_err_q, sof_err_d;

  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [BW-1:0]  cur_blk, mem_rdata;

  // Block layout: lane l real at slot 2l, imaginary at slot 2l+1.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign cur_blk[(2*l)*WIDTH   +: WIDTH] = din_i[l];
    assign cur_blk[(2*l+1)*WIDTH +: WIDTH] = din_q[l];
    assign dout1_i[l] = d1_q[(2*l)*WIDTH   +: WIDTH];
    assign dout1_q[l] = d1_q[(2*l+1)*WIDTH +: WIDTH];
    assign dout2_i[l] = d2_q[(2*l)*WIDTH   +: WIDTH];
    assign dout2_q[l] = d2_q[(2*l+1)*WIDTH +: WIDTH];
  end

  pair_buf_mem #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (cur_blk),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d      = state_q;
    blk_cnt_d    = blk_cnt_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    bfly_en_d    = 1'b0;
    frame_done_d = 1'b0;
    sof_err_d    = 1'b0;
    mem_we       = 1'b0;
    // In PAIR the low bits of blk_cnt are exactly blk_cnt-DEPTH.
    mem_addr     = blk_cnt_q[AW-1:0];

    if (din_valid) begin
      if (sof) begin
        // Any sof restarts the frame; mid-frame it also flags the abandoned one.
        sof_err_d = (state_q != IDLE);
        mem_we    = 1'b1;
        mem_addr  = '0;
        blk_cnt_d = CW'(1);
        state_d   = FILL;
      end else begin
        case (state_q)
          FILL: begin
            mem_we    = 1'b1;
            blk_cnt_d = blk_cnt_q + 1'b1;
            if (blk_cnt_q == CW'(DEPTH-1)) state_d = PAIR;
          end
          PAIR: begin
            d1_d      = mem_rdata;
            d2_d      = cur_blk;
            bfly_en_d = 1'b1;
            if (blk_cnt_q == CW'(2*DEPTH-1)) begin
              frame_done_d = 1'b1;
              blk_cnt_d    = '0;
              state_d      = IDLE;
            end else begin
              blk_cnt_d = blk_cnt_q + 1'b1;
            end
          end
          default: begin
            // IDLE without sof: block is dropped.
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      blk_cnt_q    <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      bfly_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_cnt_q    <= blk_cnt_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      bfly_en_q    <= bfly_en_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
    end
  end

  assign bfly_en    = bfly_en_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_bfly_pair_buf.sv
// Self-checking bench for bfly_pair_buf: a frame-queue reference model predicts
// every registered output cycle by cycle; scenario tasks add targeted checks.
module tb_bfly_pair_buf;

  localparam int W  = 9;
  localparam int L  = 16;
  localparam int D  = 16;
  localparam int BW = 2*L*W;

  logic clk = 1'b0;
  logic rstn, sof, din_valid;
  logic signed [W-1:0] din_i [0:L-1];
  logic signed [W-1:0] din_q [0:L-1];
  logic signed [W-1:0] dout1_i [0:L-1];
  logic signed [W-1:0] dout1_q [0:L-1];
  logic signed [W-1:0] dout2_i [0:L-1];
  logic signed [W-1:0] dout2_q [0:L-1];
  logic bfly_en, frame_done, sof_err;

  always #5 clk = ~clk;

  bfly_pair_buf #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sof        (sof),
    .din_valid  (din_valid),
    .din_i      (din_i),
    .din_q      (din_q),
    .dout1_i    (dout1_i),
    .dout1_q    (dout1_q),
    .dout2_i    (dout2_i),
    .dout2_q    (dout2_q),
    .bfly_en    (bfly_en),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int obs_en, obs_done, obs_err;

  // Reference model: the blocks of the current frame, oldest first.
  logic [BW-1:0] frm [$];
  logic [BW-1:0] exp_d1, exp_d2, cur;
  logic          exp_en, exp_done, exp_err;

  function automatic logic [BW-1:0] blk_of(input logic signed [W-1:0] a [0:L-1],
                                           input logic signed [W-1:0] b [0:L-1]);
    logic [BW-1:0] r;
    for (int k = 0; k < L; k++) begin
      r[k*W +: W]     = a[k];
      r[(L+k)*W +: W] = b[k];
    end
    return r;
  endfunction

  task automatic set_pat(input int b);
    for (int k = 0; k < L; k++) begin
      din_i[k] = W'(b*16 + k);
      din_q[k] = W'(-(b*16 + k));
    end
  endtask

  task automatic set_rand();
    for (int k = 0; k < L; k++) begin
      din_i[k] = W'($urandom);
      din_q[k] = W'($urandom);
    end
  endtask

  // One clock: drive, clock, advance the model on what was sampled, observe.
  task automatic step(input logic s, input logic v);
    sof = s;
    din_valid = v;
    @(posedge clk);
    exp_en = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    if (!rstn) begin
      frm.delete();
      exp_d1 = '0;
      exp_d2 = '0;
    end else if (v) begin
      cur = blk_of(din_i, din_q);
      if (s) begin
        exp_err = (frm.size() != 0);
        frm.delete();
        frm.push_back(cur);
      end else if (frm.size() != 0) begin
        frm.push_back(cur);
        if (frm.size() > D) begin
          exp_en = 1'b1;
          exp_d1 = frm[frm.size()-1-D];
          exp_d2 = cur;
          if (frm.size() == 2*D) begin
            exp_done = 1'b1;
            frm.delete();
          end
        end
      end
    end
    #1;
    if (bfly_en === 1'b1)    obs_en++;
    if (frame_done === 1'b1) obs_done++;
    if (sof_err === 1'b1)    obs_err++;
  endtask

  task automatic clr_obs();
    obs_en = 0; obs_done = 0; obs_err = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_rand();
    exp_d1 = 'x; exp_d2 = 'x;
    step(1'b1, 1'b1);
    n_tests++;
    if (bfly_en !== 1'b0 || frame_done !== 1'b0 || sof_err !== 1'b0 ||
        blk_of(dout1_i, dout1_q) !== '0 || blk_of(dout2_i, dout2_q) !== '0) begin
      n_fail++;
      $display("FAIL reset: got en/done/err=%b%b%b d1=%h d2=%h, want all zero",
               bfly_en, frame_done, sof_err, blk_of(dout1_i, dout1_q), blk_of(dout2_i, dout2_q));
    end
    rstn = 1'b1;
  endtask

  // Contiguous patterned frame; pairs appear on the cycles after blocks 16..31.
  task automatic test_frame();
    int first, last, k;
    clr_obs(); first = -1; last = -1;
    for (int c = 0; c < 34; c++) begin
      if (c < 32) set_pat(c);
      step(c == 0, c < 32);
      n_tests++;
      if (bfly_en !== exp_en || frame_done !== exp_done || sof_err !== exp_err ||
          blk_of(dout1_i, dout1_q) !== exp_d1 || blk_of(dout2_i, dout2_q) !== exp_d2) begin
        n_fail++;
        $display("FAIL frame cyc %0d: got %b%b%b d1=%h d2=%h, want %b%b%b d1=%h d2=%h", c,
                 bfly_en, frame_done, sof_err, blk_of(dout1_i, dout1_q), blk_of(dout2_i, dout2_q),
                 exp_en, exp_done, exp_err, exp_d1, exp_d2);
      end
      if (bfly_en === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        k = c % L;
        n_tests++;
        if (dout1_i[k] !== W'((obs_en-1)*16 + k) || dout2_i[k] !== W'((obs_en-1+16)*16 + k) ||
            dout1_q[k] !== W'(-((obs_en-1)*16 + k))) begin
          n_fail++;
          $display("FAIL pair_val pair %0d lane %0d: got d1=%0d d2=%0d q1=%0d, want %0d %0d %0d",
                   obs_en-1, k, dout1_i[k], dout2_i[k], dout1_q[k],
                   W'((obs_en-1)*16 + k), W'((obs_en-1+16)*16 + k), W'(-((obs_en-1)*16 + k)));
        end
      end
    end
    n_tests++;
    if (first != 16 || last != 31 || obs_done != 1 || obs_en != 16) begin
      n_fail++;
      $display("FAIL frame_timing: got first=%0d last=%0d pairs=%0d done=%0d, want 16 31 16 1",
               first, last, obs_en, obs_done);
    end
  endtask

  // Same frame with din_valid low every third cycle.
  task automatic test_gaps();
    int b;
    logic v;
    clr_obs(); b = 0;
    for (int c = 0; c < 60 && !(b == 32 && c > 50); c++) begin
      v = (c % 3 != 2) && (b < 32);
      if (v) set_pat(b);
      step(v && b == 0, v);
      if (v) b++;
      n_tests++;
      if (bfly_en !== exp_en || frame_done !== exp_done || sof_err !== exp_err ||
          blk_of(dout1_i, dout1_q) !== exp_d1 || blk_of(dout2_i, dout2_q) !== exp_d2) begin
        n_fail++;
        $display("FAIL gaps cyc %0d: got %b%b%b d1=%h d2=%h, want %b%b%b d1=%h d2=%h", c,
                 bfly_en, frame_done, sof_err, blk_of(dout1_i, dout1_q), blk_of(dout2_i, dout2_q),
                 exp_en, exp_done, exp_err, exp_d1, exp_d2);
      end
    end
    n_tests++;
    if (obs_en != 16 || obs_done != 1 || b != 32) begin
      n_fail++;
      $display("FAIL gaps_count: got pairs=%0d done=%0d blocks=%0d, want 16 1 32", obs_en, obs_done, b);
    end
  endtask

  // Unframed blocks are dropped, then a normal frame.
  task automatic test_idle_drop();
    clr_obs();
    for (int c = 0; c < 38; c++) begin
      if (c < 5) set_rand(); else set_pat(c - 5);
      step(c == 5, c < 37);
      n_tests++;
      if (bfly_en !== exp_en || frame_done !== exp_done || sof_err !== exp_err ||
          blk_of(dout1_i, dout1_q) !== exp_d1 || blk_of(dout2_i, dout2_q) !== exp_d2) begin
        n_fail++;
        $display("FAIL idle_drop cyc %0d: got %b%b%b d1=%h d2=%h, want %b%b%b d1=%h d2=%h", c,
                 bfly_en, frame_done, sof_err, blk_of(dout1_i, dout1_q), blk_of(dout2_i, dout2_q),
                 exp_en, exp_done, exp_err, exp_d1, exp_d2);
      end
    end
    n_tests++;
    if (obs_en != 16 || obs_done != 1 || obs_err != 0) begin
      n_fail++;
      $display("FAIL idle_drop_count: got pairs=%0d done=%0d err=%0d, want 16 1 0", obs_en, obs_done, obs_err);
    end
  endtask

  // sof arrives as block 20; the old frame's 4 pairs stand, no frame_done for it.
  task automatic test_sof_mid();
    clr_obs();
    for (int c = 0; c < 54; c++) begin
      set_rand();
      step(c == 0 || c == 20, c < 52);
      n_tests++;
      if (bfly_en !== exp_en || frame_done !== exp_done || sof_err !== exp_err ||
          blk_of(dout1_i, dout1_q) !== exp_d1 || blk_of(dout2_i, dout2_q) !== exp_d2) begin
        n_fail++;
        $display("FAIL sof_mid cyc %0d: got %b%b%b d1=%h d2=%h, want %b%b%b d1=%h d2=%h", c,
                 bfly_en, frame_done, sof_err, blk_of(dout1_i, dout1_q), blk_of(dout2_i, dout2_q),
                 exp_en, exp_done, exp_err, exp_d1, exp_d2);
      end
    end
    n_tests++;
    if (obs_err != 1 || obs_done != 1 || obs_en != 20) begin
      n_fail++;
      $display("FAIL sof_mid_count: got err=%0d done=%0d pairs=%0d, want 1 1 20", obs_err, obs_done, obs_en);
    end
  endtask

  // Reset pulse mid-PAIR, some dropped blocks, then a clean frame.
  task automatic test_reset_mid();
    for (int c = 0; c < 60; c++) begin
      set_rand();
      rstn = (c != 20);
      if (c == 21) clr_obs();
      step(c == 0 || c == 25, c < 57);
      n_tests++;
      if (bfly_en !== exp_en || frame_done !== exp_done || sof_err !== exp_err ||
          blk_of(dout1_i, dout1_q) !== exp_d1 || blk_of(dout2_i, dout2_q) !== exp_d2) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: got %b%b%b d1=%h d2=%h, want %b%b%b d1=%h d2=%h", c,
                 bfly_en, frame_done, sof_err, blk_of(dout1_i, dout1_q), blk_of(dout2_i, dout2_q),
                 exp_en, exp_done, exp_err, exp_d1, exp_d2);
      end
    end
    rstn = 1'b1;
    n_tests++;
    if (obs_en != 16 || obs_done != 1 || obs_err != 0) begin
      n_fail++;
      $display("FAIL reset_mid_count: got pairs=%0d done=%0d err=%0d, want 16 1 0", obs_en, obs_done, obs_err);
    end
  endtask

  // Full-scale values, two frames back to back with no bubble.
  task automatic test_back_to_back();
    logic signed [W-1:0] want;
    clr_obs();
    for (int c = 0; c < 66; c++) begin
      for (int k = 0; k < L; k++) begin
        din_i[k] = ((c + k) % 2 == 1) ? W'(255) : W'(-256);
        din_q[k] = ((c + k) % 2 == 1) ? W'(-256) : W'(255);
      end
      step(c % 32 == 0 && c < 64, c < 64);
      n_tests++;
      if (bfly_en !== exp_en || frame_done !== exp_done || sof_err !== exp_err ||
          blk_of(dout1_i, dout1_q) !== exp_d1 || blk_of(dout2_i, dout2_q) !== exp_d2) begin
        n_fail++;
        $display("FAIL b2b cyc %0d: got %b%b%b d1=%h d2=%h, want %b%b%b d1=%h d2=%h", c,
                 bfly_en, frame_done, sof_err, blk_of(dout1_i, dout1_q), blk_of(dout2_i, dout2_q),
                 exp_en, exp_done, exp_err, exp_d1, exp_d2);
      end
      if (bfly_en === 1'b1) begin
        want = (c % 2 == 1) ? W'(255) : W'(-256);
        n_tests++;
        if (dout2_i[0] !== want || dout1_i[0] !== want) begin
          n_fail++;
          $display("FAIL extreme cyc %0d: got d1_i0=%0d d2_i0=%0d, want %0d", c, dout1_i[0], dout2_i[0], want);
        end
      end
    end
    n_tests++;
    if (obs_en != 32 || obs_done != 2 || obs_err != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got pairs=%0d done=%0d err=%0d, want 32 2 0", obs_en, obs_done, obs_err);
    end
  endtask

  // Random valid gaps and occasional sof anywhere.
  task automatic test_random();
    logic v, s;
    for (int c = 0; c < 500; c++) begin
      set_rand();
      v = ($urandom_range(0, 3) != 0);
      s = (c == 0) || ($urandom_range(0, 39) == 0);
      step(s, v || c == 0);
      n_tests++;
      if (bfly_en !== exp_en || frame_done !== exp_done || sof_err !== exp_err ||
          blk_of(dout1_i, dout1_q) !== exp_d1 || blk_of(dout2_i, dout2_q) !== exp_d2) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b%b%b d1=%h d2=%h, want %b%b%b d1=%h d2=%h", c,
                 bfly_en, frame_done, sof_err, blk_of(dout1_i, dout1_q), blk_of(dout2_i, dout2_q),
                 exp_en, exp_done, exp_err, exp_d1, exp_d2);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; sof = 1'b0; din_valid = 1'b0;
    set_rand();
    exp_en = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_d1 = '0; exp_d2 = '0;
    @(negedge clk);
    test_reset();
    test_frame();
    test_gaps();
    test_idle_drop();
    test_sof_mid();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
